reg_file_ba: RTL and testbench
==============================

# reg_file_ba

Parametrised multi-port general-purpose register file for the CPU datapath. It replaces the individual R0..Rn register instances with one array. It provides one synchronous write port and NRD registered read ports. Each read port has its own BAout gating so that register 0 reads as zero during base-address computation. Write-to-read bypass is included so back-to-back dependent instructions see fresh data.

## Interface
Parameters:
- WIDTH, 32, data width of every register
- NREGS, 16, number of registers; power of two, ≥2
- NRD, 2, number of read ports, ≥1
- AW, $clog2(NREGS), address width (derived, not overridden)
- R0_BA, 1, 1 = BAout gating applies to register 0 only; 0 = BAout gating applies to whatever register is addressed

Ports:
- clk  in  1  single clock; all state updates on rising edge
- clr  in  1  asynchronous, active-high reset; clears every register and every read output
- wr_en  in  1  write enable
- wr_addr  in  AW  write register index
- wr_data  in  WIDTH  write data
- rd_en  in  NRD  per-port read enable; low = port output holds
- rd_addr  in  NRD*AW  packed read indices; port p at [p*AW +: AW]
- rd_ba  in  NRD  per-port BAout
- rd_data  out  NRD*WIDTH  packed registered read data; port p at [p*WIDTH +: WIDTH]

## Operation
- Reset: clr high → all NREGS registers = 0 and rd_data = 0 immediately (asynchronous). Held while clr is high; wr_en and rd_en are ignored.
- Write: at a rising edge with wr_en=1, reg[wr_addr] ← wr_data. Writes to register 0 are stored normally; zero-forcing happens only on read.
- Read, port p, at a rising edge with rd_en[p]=1:
  - gated = rd_ba[p] && (R0_BA==0 || rd_addr_p==0)
  - gated → rd_data_p ← 0
  - else if wr_en && wr_addr==rd_addr_p → rd_data_p ← wr_data (bypass, new value)
  - else → rd_data_p ← reg[rd_addr_p]
- rd_en[p]=0 → rd_data_p holds its previous value, even if the addressed register is written.
- Multiple ports may read the same address in the same cycle. Each port gets an identical result except for its own rd_ba gating.
- Gating has priority over bypass. With BA gating on register 0, a same-cycle write to register 0 still reads 0 on that port, and the write still lands.
- No read-side effects; the array changes only through the write port.

## Timing
- Write latency: 1 edge. Data is visible in reg on the edge where wr_en is sampled.
- Read latency: 1 edge. rd_data reflects the address, ba, and bypass conditions sampled at that edge.
- Effective write-to-read latency through bypass: 1 edge, with no stall cycle.
- clr asserted mid-cycle: outputs drop to 0 without waiting for clk. Any write pending in that cycle is lost.
- clr deassertion: the first edge with clr low performs normal write/read.
- Inputs are sampled only at rising edges. rd_data is glitch-free between edges, being driven directly from flops.

## Structure
- Shared package (`reg_file_pkg`):
  - default WIDTH/NREGS/NRD constants
  - the AW derivation
  - register index constant `REG_ZERO = 0`
  - a packed-slice helper function for port p address and data extraction
- Natural sub-module: `rf_read_port`, one instance per read port via generate. It contains the gating, bypass, hold mux and output flop, and takes the array read value, wr_en, wr_addr and wr_data as inputs.
- The storage array and write logic stay in the top level.

## Test plan
- Reset: write 0xDEADBEEF to reg 5, then pulse clr between edges → rd_data drops to 0 at once; reading reg 5 after release returns 0.
- Write/read: write 0x12345678 to reg 3; next cycle, port0 reads reg 3 with rd_ba=0 → 0x12345678 one edge later. Port1 reading reg 3 in the same cycle gets the identical value.
- Bypass: in the same cycle, wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5, and port0 rd_addr=7 → rd_data_0 = 0xA5A5A5A5 after that edge, not the old contents.
- BAout: reg 0 = 0x0000FFFF; port0 reads reg 0 with rd_ba=1 → 0; with rd_ba=0 → 0x0000FFFF. Port1 reads reg 4 with rd_ba=1 under R0_BA=1 → unaffected. Repeat under R0_BA=0 → 0.
- Hold: port1 latches 0x11 from reg 2; rd_en[1]=0 while reg 2 is rewritten to 0x22 → rd_data_1 stays 0x11; rd_en[1]=1 → 0x22.
- Parameter sweep: WIDTH=8, NREGS=4, NRD=3 → repeat the bypass and BA scenarios with scaled values, checking packed-slice alignment on all ports.

Source files
------------

// File: rtl/reg_file_ba_pkg.sv
// Shared constants and helpers for the base-address-aware register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_file_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREGS = 16;
    localparam int DEF_NRD   = 2;

    // Index of the register that reads as zero during base-address computation.
    localparam int REG_ZERO = 0;

    // Register index width for a given register count.
    function automatic int addr_w(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    // Low bit of port p's field inside a packed per-port bus of field width w.
    function automatic int slice_lo(input int p, input int w);
        return p * w;
    endfunction

endpackage

// File: rtl/reg_file_ba_if.sv
// Write port and packed read-port bundle of the register file.
// Latency: n/a (wiring only).
// Backpressure: none; every write and enabled read is taken on the next edge.
interface reg_file_ba_if import reg_file_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = DEF_NRD
);
    localparam int AW = addr_w(NREGS);

    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [WIDTH-1:0]     wr_data;
    logic [NRD-1:0]       rd_en;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD-1:0]       rd_ba;
    logic [NRD*WIDTH-1:0] rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_ba,
        input  rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_ba,
        output rd_data
    );

endinterface

// File: rtl/reg_file_ba_read_port.sv
// One registered read port: BAout zero-gating, write bypass, hold when disabled.
// Latency: 1 edge from address/ba/bypass sampling to rd_data.
// Backpressure: none; rd_en low simply freezes the output flop.
module rf_read_port import reg_file_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = 4,
    parameter int R0_BA = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             rd_en,
    input  logic             rd_ba,
    input  logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] arr_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic             gated;
    logic             bypass;
    logic [WIDTH-1:0] next_data;

    // Select zero, the in-flight write, or the stored value; gating wins over bypass.
    always_comb begin
        gated     = rd_ba && ((R0_BA == 0) || (rd_addr == AW'(REG_ZERO)));
        bypass    = wr_en && (wr_addr == rd_addr);
        next_data = arr_data;
        if (gated) begin
            next_data = '0;
        end else if (bypass) begin
            next_data = wr_data;
        end
    end

    // Output flop: cleared asynchronously, loaded only when the port is enabled.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= next_data;
        end
    end

endmodule

// File: rtl/reg_file_ba.sv
// Register file: one synchronous write port, NRD registered read ports with BAout gating.
// Latency: 1 edge write, 1 edge read, 1 edge write-to-read through the bypass.
// Backpressure: none; ports accept every cycle, disabled read ports hold.
module reg_file_ba import reg_file_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = DEF_NRD,
    parameter int R0_BA = 1
) (
    input  logic          clk,
    input  logic          clr,
    reg_file_ba_if.slave  bus
);

    localparam int AW = addr_w(NREGS);

    logic [WIDTH-1:0] regs   [NREGS];
    logic [AW-1:0]    addr_p [NRD];
    logic [WIDTH-1:0] data_p [NRD];

    // Storage array; register 0 is stored like any other, zeroing happens on read.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wr_en) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Split the packed address bus into per-port indices.
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            addr_p[p] = bus.rd_addr[slice_lo(p, AW) +: AW];
        end
    end

    // Reassemble per-port flop outputs into the packed read-data bus.
    always_comb begin
        bus.rd_data = '0;
        for (int p = 0; p < NRD; p++) begin
            bus.rd_data[slice_lo(p, WIDTH) +: WIDTH] = data_p[p];
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_port
        rf_read_port #(
            .WIDTH (WIDTH),
            .AW    (AW),
            .R0_BA (R0_BA)
        ) u_port (
            .clk      (clk),
            .clr      (clr),
            .rd_en    (bus.rd_en[p]),
            .rd_ba    (bus.rd_ba[p]),
            .rd_addr  (addr_p[p]),
            .arr_data (regs[addr_p[p]]),
            .wr_en    (bus.wr_en),
            .wr_addr  (bus.wr_addr),
            .wr_data  (bus.wr_data),
            .rd_data  (data_p[p])
        );
    end

endmodule

// File: tb/tb_reg_file_ba.sv
// Bench for reg_file_ba: default config with R0_BA=1 and R0_BA=0, plus an 8-bit/4-reg/3-port sweep.
// Latency: expectations compared #1 after the edge that produces them.
// Backpressure: n/a.
module tb_reg_file_ba;

    logic clk = 1'b0;
    logic clr = 1'b1;

    always #5 clk = ~clk;

    reg_file_ba_if bus_a ();
    reg_file_ba_if bus_b ();
    reg_file_ba_if #(.WIDTH(8), .NREGS(4), .NRD(3)) bus_c ();

    // The R0_BA=0 instance sees exactly the same stimulus as the R0_BA=1 instance.
    assign bus_b.wr_en   = bus_a.wr_en;
    assign bus_b.wr_addr = bus_a.wr_addr;
    assign bus_b.wr_data = bus_a.wr_data;
    assign bus_b.rd_en   = bus_a.rd_en;
    assign bus_b.rd_addr = bus_a.rd_addr;
    assign bus_b.rd_ba   = bus_a.rd_ba;

    reg_file_ba #(.R0_BA(1)) dut_a (.clk(clk), .clr(clr), .bus(bus_a));
    reg_file_ba #(.R0_BA(0)) dut_b (.clk(clk), .clr(clr), .bus(bus_b));
    reg_file_ba #(.WIDTH(8), .NREGS(4), .NRD(3), .R0_BA(1)) dut_c (.clk(clk), .clr(clr), .bus(bus_c));

    typedef struct {
        string       name;
        int          dut;
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [31:0] rd_of(input int dut, input int port);
        case (dut)
            0:       return bus_a.rd_data[port*32 +: 32];
            1:       return bus_b.rd_data[port*32 +: 32];
            default: return {24'h0, bus_c.rd_data[port*8 +: 8]};
        endcase
    endfunction

    task automatic expect_val(input string n, input int dut, input int port, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.dut  = dut;
        e.port = port;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_a.wr_en = 1'b0;
        bus_a.rd_en = '0;
        bus_a.rd_ba = '0;
        bus_c.wr_en = 1'b0;
        bus_c.rd_en = '0;
        bus_c.rd_ba = '0;
    endtask

    task automatic wr(input bit en, input int addr, input logic [31:0] d);
        bus_a.wr_en   = en;
        bus_a.wr_addr = 4'(addr);
        bus_a.wr_data = d;
    endtask

    task automatic rd(input int p, input bit en, input int addr, input bit ba);
        bus_a.rd_en[p]          = en;
        bus_a.rd_addr[p*4 +: 4] = 4'(addr);
        bus_a.rd_ba[p]          = ba;
    endtask

    task automatic wr_c(input bit en, input int addr, input logic [7:0] d);
        bus_c.wr_en   = en;
        bus_c.wr_addr = 2'(addr);
        bus_c.wr_data = d;
    endtask

    task automatic rd_c(input int p, input bit en, input int addr, input bit ba);
        bus_c.rd_en[p]          = en;
        bus_c.rd_addr[p*2 +: 2] = 2'(addr);
        bus_c.rd_ba[p]          = ba;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] act;
        for (int s = 0; s < 4; s++) begin
            case (s)
                0: begin
                    for (int p = 0; p < 2; p++) begin
                        expect_val("reset_a", 0, p, 32'h0);
                        expect_val("reset_b", 1, p, 32'h0);
                    end
                    for (int p = 0; p < 3; p++) expect_val("reset_c", 2, p, 32'h0);
                end
                1: begin
                    clr = 1'b0;
                    idle();
                    wr(1, 5, 32'hDEADBEEF);
                    rd(0, 1, 5, 0);
                    expect_val("pre_clr_rd", 0, 0, 32'hDEADBEEF);
                    tick();
                end
                2: begin
                    idle();
                    #2 clr = 1'b1;
                    #1;
                    expect_val("async_clr_a", 0, 0, 32'h0);
                    expect_val("async_clr_b", 1, 0, 32'h0);
                    clr = 1'b0;
                end
                default: begin
                    idle();
                    rd(0, 1, 5, 0);
                    rd(1, 1, 5, 0);
                    expect_val("post_clr_p0", 0, 0, 32'h0);
                    expect_val("post_clr_p1", 0, 1, 32'h0);
                    tick();
                end
            endcase
            while (sb.size() > 0) begin
                e = sb.pop_front();
                act = rd_of(e.dut, e.port);
                checks++;
                if (act !== e.val) begin
                    failures++;
                    $display("FAIL %s dut%0d port%0d got=%h expected=%h", e.name, e.dut, e.port, act, e.val);
                end
            end
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        logic [31:0] act;
        for (int s = 0; s < 2; s++) begin
            idle();
            case (s)
                0: wr(1, 3, 32'h12345678);
                default: begin
                    rd(0, 1, 3, 0);
                    rd(1, 1, 3, 0);
                    expect_val("wr_rd_p0_a", 0, 0, 32'h12345678);
                    expect_val("wr_rd_p1_a", 0, 1, 32'h12345678);
                    expect_val("wr_rd_p0_b", 1, 0, 32'h12345678);
                    expect_val("wr_rd_p1_b", 1, 1, 32'h12345678);
                end
            endcase
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                act = rd_of(e.dut, e.port);
                checks++;
                if (act !== e.val) begin
                    failures++;
                    $display("FAIL %s dut%0d port%0d got=%h expected=%h", e.name, e.dut, e.port, act, e.val);
                end
            end
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        logic [31:0] act;
        for (int s = 0; s < 3; s++) begin
            idle();
            case (s)
                0: wr(1, 7, 32'h11111111);
                1: begin
                    wr(1, 7, 32'hA5A5A5A5);
                    rd(0, 1, 7, 0);
                    expect_val("bypass_a", 0, 0, 32'hA5A5A5A5);
                    expect_val("bypass_b", 1, 0, 32'hA5A5A5A5);
                end
                default: begin
                    rd(1, 1, 7, 0);
                    expect_val("bypass_landed", 0, 1, 32'hA5A5A5A5);
                    expect_val("bypass_p0_hold", 0, 0, 32'hA5A5A5A5);
                end
            endcase
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                act = rd_of(e.dut, e.port);
                checks++;
                if (act !== e.val) begin
                    failures++;
                    $display("FAIL %s dut%0d port%0d got=%h expected=%h", e.name, e.dut, e.port, act, e.val);
                end
            end
        end
    endtask

    task automatic test_ba();
        exp_t e;
        logic [31:0] act;
        for (int s = 0; s < 6; s++) begin
            idle();
            case (s)
                0: wr(1, 0, 32'h0000FFFF);
                1: wr(1, 4, 32'h44444444);
                2: begin
                    rd(0, 1, 0, 1);
                    rd(1, 1, 4, 1);
                    expect_val("ba_r0_gated_a", 0, 0, 32'h0);
                    expect_val("ba_r4_pass_a", 0, 1, 32'h44444444);
                    expect_val("ba_r0_gated_b", 1, 0, 32'h0);
                    expect_val("ba_r4_gated_b", 1, 1, 32'h0);
                end
                3: begin
                    rd(0, 1, 0, 0);
                    rd(1, 1, 4, 0);
                    expect_val("ba_off_r0_a", 0, 0, 32'h0000FFFF);
                    expect_val("ba_off_r4_a", 0, 1, 32'h44444444);
                    expect_val("ba_off_r0_b", 1, 0, 32'h0000FFFF);
                    expect_val("ba_off_r4_b", 1, 1, 32'h44444444);
                end
                4: begin
                    wr(1, 0, 32'hBEEF0000);
                    rd(0, 1, 0, 1);
                    rd(1, 1, 0, 0);
                    expect_val("ba_over_bypass_a", 0, 0, 32'h0);
                    expect_val("ba_other_bypass_a", 0, 1, 32'hBEEF0000);
                    expect_val("ba_over_bypass_b", 1, 0, 32'h0);
                    expect_val("ba_other_bypass_b", 1, 1, 32'hBEEF0000);
                end
                default: begin
                    rd(0, 1, 0, 0);
                    expect_val("ba_write_landed_a", 0, 0, 32'hBEEF0000);
                    expect_val("ba_write_landed_b", 1, 0, 32'hBEEF0000);
                end
            endcase
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                act = rd_of(e.dut, e.port);
                checks++;
                if (act !== e.val) begin
                    failures++;
                    $display("FAIL %s dut%0d port%0d got=%h expected=%h", e.name, e.dut, e.port, act, e.val);
                end
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        logic [31:0] act;
        for (int s = 0; s < 5; s++) begin
            idle();
            case (s)
                0: wr(1, 2, 32'h11);
                1: begin
                    rd(1, 1, 2, 0);
                    expect_val("hold_latch", 0, 1, 32'h11);
                end
                2: begin
                    wr(1, 2, 32'h22);
                    expect_val("hold_during_wr", 0, 1, 32'h11);
                end
                3: expect_val("hold_idle", 0, 1, 32'h11);
                default: begin
                    rd(1, 1, 2, 0);
                    expect_val("hold_release", 0, 1, 32'h22);
                end
            endcase
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                act = rd_of(e.dut, e.port);
                checks++;
                if (act !== e.val) begin
                    failures++;
                    $display("FAIL %s dut%0d port%0d got=%h expected=%h", e.name, e.dut, e.port, act, e.val);
                end
            end
        end
    endtask

    task automatic test_sweep();
        exp_t e;
        logic [31:0] act;
        for (int s = 0; s < 5; s++) begin
            idle();
            case (s)
                0: wr_c(1, 1, 8'h5A);
                1: begin
                    wr_c(1, 2, 8'hC3);
                    rd_c(0, 1, 2, 0);
                    rd_c(1, 1, 1, 0);
                    rd_c(2, 1, 2, 1);
                    expect_val("sw_bypass_p0", 2, 0, 32'hC3);
                    expect_val("sw_stored_p1", 2, 1, 32'h5A);
                    expect_val("sw_ba_nonzero_p2", 2, 2, 32'hC3);
                end
                2: wr_c(1, 0, 8'h7E);
                3: begin
                    wr_c(1, 3, 8'h3C);
                    rd_c(0, 1, 0, 1);
                    rd_c(1, 1, 0, 0);
                    rd_c(2, 1, 2, 0);
                    expect_val("sw_ba_r0_p0", 2, 0, 32'h0);
                    expect_val("sw_r0_p1", 2, 1, 32'h7E);
                    expect_val("sw_r2_p2", 2, 2, 32'hC3);
                end
                default: begin
                    wr_c(1, 0, 8'h99);
                    rd_c(0, 1, 0, 0);
                    rd_c(1, 1, 3, 0);
                    rd_c(2, 1, 0, 1);
                    expect_val("sw_bypass_r0_p0", 2, 0, 32'h99);
                    expect_val("sw_r3_p1", 2, 1, 32'h3C);
                    expect_val("sw_ba_bypass_p2", 2, 2, 32'h0);
                end
            endcase
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                act = rd_of(e.dut, e.port);
                checks++;
                if (act !== e.val) begin
                    failures++;
                    $display("FAIL %s dut%0d port%0d got=%h expected=%h", e.name, e.dut, e.port, act, e.val);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] act;
        logic [31:0] v;
        for (int s = 0; s < 8; s++) begin
            idle();
            v = 32'h01010101 * 32'(s + 1) ^ 32'h80000000;
            wr(1, 9, v);
            rd(0, 1, 9, 0);
            rd(1, 1, 9, 1);
            expect_val("b2b_p0_a", 0, 0, v);
            expect_val("b2b_p1_ba_a", 0, 1, v);
            expect_val("b2b_p0_b", 1, 0, v);
            expect_val("b2b_p1_ba_b", 1, 1, 32'h0);
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                act = rd_of(e.dut, e.port);
                checks++;
                if (act !== e.val) begin
                    failures++;
                    $display("FAIL %s dut%0d port%0d got=%h expected=%h", e.name, e.dut, e.port, act, e.val);
                end
            end
        end
    endtask

    initial begin
        bus_a.wr_en   = 1'b0;
        bus_a.wr_addr = '0;
        bus_a.wr_data = '0;
        bus_a.rd_en   = '0;
        bus_a.rd_addr = '0;
        bus_a.rd_ba   = '0;
        bus_c.wr_en   = 1'b0;
        bus_c.wr_addr = '0;
        bus_c.wr_data = '0;
        bus_c.rd_en   = '0;
        bus_c.rd_addr = '0;
        bus_c.rd_ba   = '0;
        #3;
        test_reset();
        test_write_read();
        test_bypass();
        test_ba();
        test_hold();
        test_sweep();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
